// File: rtl/ddr3_test_pkg.sv
// Shared encodings for the DDR3 loopback traffic checker: pattern modes,
// controller states and Galois LFSR tap masks.
package ddr3_test_pkg;

  localparam logic [1:0] MODE_INC     = 2'd0;
  localparam logic [1:0] MODE_WALK    = 2'd1;
  localparam logic [1:0] MODE_LFSR    = 2'd2;
  localparam logic [1:0] MODE_CHECKER = 2'd3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Right-shifting Galois masks: x^8+x^6+x^5+x^4+1, x^16+x^14+x^13+x^11+1,
  // x^32+x^22+x^2+x^1+1.
  localparam logic [31:0] LFSR_TAPS_8  = 32'h0000_00B8;
  localparam logic [31:0] LFSR_TAPS_16 = 32'h0000_B400;
  localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;

  function automatic logic [31:0] lfsr_taps(input int unsigned width);
    case (width)
      8:       lfsr_taps = LFSR_TAPS_8;
      16:      lfsr_taps = LFSR_TAPS_16;
      default: lfsr_taps = LFSR_TAPS_32;
    endcase
  endfunction

endpackage

// File: rtl/ddr3_test_pattern_gen.sv
// Test data pattern generator: load seeds the selected pattern (mode is
// latched on load), advance steps it to the next word.
module ddr3_test_pattern_gen
  import ddr3_test_pkg::*;
#(
  parameter int unsigned DQ_BITWIDTH = 16,
  parameter logic [31:0] LFSR_SEED   = 32'h0000_0001
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic                   advance,
  input  logic [1:0]             mode,
  output logic [DQ_BITWIDTH-1:0] data
);

  localparam logic [DQ_BITWIDTH-1:0] ONE      = {{(DQ_BITWIDTH-1){1'b0}}, 1'b1};
  localparam logic [DQ_BITWIDTH-1:0] TAPS     = DQ_BITWIDTH'(lfsr_taps(DQ_BITWIDTH));
  localparam logic [DQ_BITWIDTH-1:0] SEED_RAW = LFSR_SEED[DQ_BITWIDTH-1:0];
  localparam logic [DQ_BITWIDTH-1:0] SEED     = (SEED_RAW == '0) ? ONE : SEED_RAW;
  localparam logic [DQ_BITWIDTH-1:0] CHECKER  = {(DQ_BITWIDTH/2){2'b10}};

  logic [DQ_BITWIDTH-1:0] data_q, data_d;
  logic [1:0]             mode_q, mode_d;

  always_comb begin
    data_d = data_q;
    mode_d = mode_q;
    if (load) begin
      mode_d = mode;
      case (mode)
        MODE_INC, MODE_WALK: data_d = ONE;
        MODE_LFSR:           data_d = SEED;
        default:             data_d = CHECKER;
      endcase
    end else if (advance) begin
      case (mode_q)
        MODE_INC:  data_d = data_q + ONE;
        MODE_WALK: data_d = {data_q[DQ_BITWIDTH-2:0], data_q[DQ_BITWIDTH-1]};
        MODE_LFSR: data_d = (data_q >> 1) ^ (data_q[0] ? TAPS : '0);
        default:   data_d = ~data_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
      mode_q <= MODE_INC;
    end else begin
      data_q <= data_d;
      mode_q <= mode_d;
    end
  end

  assign data = data_q;

endmodule

// File: rtl/ddr3_loopback_traffic_checker.sv
// Writes NUM_OF_TEST_DATA pattern words through the DDR3 controller, reads
// them back in order and checks them. Optional read watchdog: TRAFFIC_CHECKER_READ_TIMEOUT_EN.
module ddr3_loopback_traffic_checker
  import ddr3_test_pkg::*;
#(
  parameter int unsigned DQ_BITWIDTH           = 16,
  parameter int unsigned ADDRESS_BITWIDTH      = 15,
  parameter int unsigned BANK_ADDRESS_BITWIDTH = 3,
  parameter int unsigned NUM_OF_TEST_DATA      = 4,
  parameter int unsigned START_ADDRESS         = 0,
  parameter int unsigned ADDRESS_STRIDE        = 1,
  parameter int unsigned MAX_OUTSTANDING       = 4,
  parameter logic [31:0] LFSR_SEED             = 32'h0000_0001,
  parameter int unsigned TIMEOUT_CYCLES        = 1024
) (
  input  logic                                             clk,
  input  logic                                             reset,
  input  logic                                             start,
  input  logic [1:0]                                       mode,
  input  logic                                             ctrl_ready,
  output logic                                             write_enable,
  output logic                                             read_enable,
  output logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] i_user_data_address,
  output logic [DQ_BITWIDTH-1:0]                           i_user_data,
  input  logic [DQ_BITWIDTH-1:0]                           o_user_data,
  input  logic                                             o_user_data_valid,
  output logic                                             busy,
  output logic                                             done,
  output logic                                             pass,
  output logic [15:0]                                      error_count,
  output logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] first_error_address,
  output logic                                             timeout
);

  localparam int unsigned AW = BANK_ADDRESS_BITWIDTH + ADDRESS_BITWIDTH;
  localparam int unsigned CW = $clog2(NUM_OF_TEST_DATA + 1);
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] N_C      = CW'(NUM_OF_TEST_DATA);
  localparam logic [CW-1:0] N_LAST   = CW'(NUM_OF_TEST_DATA - 1);
  localparam logic [OW-1:0] MAX_C    = OW'(MAX_OUTSTANDING);
  localparam logic [AW-1:0] START_C  = AW'(START_ADDRESS);
  localparam logic [AW-1:0] STRIDE_C = AW'(ADDRESS_STRIDE);

  logic [1:0]             state_q, state_d;
  logic [AW-1:0]          addr_q, addr_d;
  logic [AW-1:0]          ret_addr_q, ret_addr_d;
  logic [CW-1:0]          issued_q, issued_d;
  logic [CW-1:0]          rcv_q, rcv_d;
  logic [OW-1:0]          outst_q, outst_d;
  logic [15:0]            err_cnt_q, err_cnt_d;
  logic [AW-1:0]          first_err_q, first_err_d;
  logic [DQ_BITWIDTH-1:0] wr_data, exp_data;
  logic                   wr_adv, exp_adv;
  logic                   start_go, cmd_accept, err_inc, mismatch, tmo_fire;

  assign write_enable = (state_q == ST_WRITE);
  assign read_enable  = (state_q == ST_READ) && (issued_q < N_C) && (outst_q < MAX_C);
  assign cmd_accept   = (write_enable | read_enable) & ctrl_ready;
  assign start_go     = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  ddr3_test_pattern_gen #(.DQ_BITWIDTH(DQ_BITWIDTH), .LFSR_SEED(LFSR_SEED)) u_wr_gen (
    .clk(clk), .reset(reset), .load(start_go), .advance(wr_adv), .mode(mode), .data(wr_data)
  );

  ddr3_test_pattern_gen #(.DQ_BITWIDTH(DQ_BITWIDTH), .LFSR_SEED(LFSR_SEED)) u_exp_gen (
    .clk(clk), .reset(reset), .load(start_go), .advance(exp_adv), .mode(mode), .data(exp_data)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    ret_addr_d  = ret_addr_q;
    issued_d    = issued_q;
    rcv_d       = rcv_q;
    outst_d     = outst_q;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;
    wr_adv      = 1'b0;
    exp_adv     = 1'b0;
    mismatch    = 1'b0;
    err_inc     = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_go) begin
          state_d     = ST_WRITE;
          addr_d      = START_C;
          ret_addr_d  = START_C;
          issued_d    = '0;
          rcv_d       = '0;
          outst_d     = '0;
          err_cnt_d   = '0;
          first_err_d = '0;
        end
      end
      ST_WRITE: begin
        if (cmd_accept) begin
          wr_adv = 1'b1;
          if (issued_q == N_LAST) begin
            state_d  = ST_READ;
            addr_d   = START_C;
            issued_d = '0;
          end else begin
            addr_d   = addr_q + STRIDE_C;
            issued_d = issued_q + 1'b1;
          end
        end
      end
      default: begin
        if (cmd_accept) begin
          addr_d   = addr_q + STRIDE_C;
          issued_d = issued_q + 1'b1;
        end
        // A return in the same cycle as an issue leaves outstanding unchanged.
        if (cmd_accept && !o_user_data_valid) begin
          outst_d = outst_q + 1'b1;
        end else if (!cmd_accept && o_user_data_valid && (outst_q != '0)) begin
          outst_d = outst_q - 1'b1;
        end
        if (o_user_data_valid) begin
          exp_adv    = 1'b1;
          ret_addr_d = ret_addr_q + STRIDE_C;
          rcv_d      = rcv_q + 1'b1;
          mismatch   = (o_user_data != exp_data);
          err_inc    = mismatch;
          if (rcv_q == N_LAST) begin
            state_d = ST_DONE;
          end
        end
        if (tmo_fire) begin
          state_d = ST_DONE;
        end
      end
    endcase
    // Returns outside READ (including any beyond the last word) are stray.
    if (o_user_data_valid && (state_q != ST_READ) && !start_go) begin
      err_inc = 1'b1;
    end
    if (err_inc) begin
      if (err_cnt_q != '1) begin
        err_cnt_d = err_cnt_q + 16'd1;
      end
      if (mismatch && (err_cnt_q == '0)) begin
        first_err_d = ret_addr_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      ret_addr_q  <= '0;
      issued_q    <= '0;
      rcv_q       <= '0;
      outst_q     <= '0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      ret_addr_q  <= ret_addr_d;
      issued_q    <= issued_d;
      rcv_q       <= rcv_d;
      outst_q     <= outst_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
    end
  end

`ifdef TRAFFIC_CHECKER_READ_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          timeout_q, timeout_d;

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    timeout_d = timeout_q;
    tmo_fire  = 1'b0;
    if (start_go) begin
      tmo_cnt_d = '0;
      timeout_d = 1'b0;
    end else if (state_q == ST_READ) begin
      if (cmd_accept || o_user_data_valid) begin
        tmo_cnt_d = '0;
      end else if ((outst_q != '0) || (issued_q < N_C)) begin
        if (tmo_cnt_q == TMO_LAST) begin
          tmo_fire  = 1'b1;
          timeout_d = 1'b1;
          tmo_cnt_d = '0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign tmo_fire = 1'b0;
  assign timeout  = 1'b0;
`endif

  assign busy                = (state_q == ST_WRITE) || (state_q == ST_READ);
  assign done                = (state_q == ST_DONE);
  assign pass                = done && (err_cnt_q == '0) && !timeout;
  assign i_user_data_address = addr_q;
  assign i_user_data         = wr_data;
  assign error_count         = err_cnt_q;
  assign first_error_address = first_err_q;

endmodule
